load_store_unit: RTL and testbench

- Pipeline memory stage between the CPU execute stage and the data port of the memory controller.
- Accepts one load/store request per transaction. Decodes the RISC-V funct3 into width and zero-extend controls, and checks alignment and the address region.
- Drives single-cycle memory strobes, honours the data stall, captures load data one cycle after the strobe, and returns a writeback result or an exception.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_decode.sv | 69 ++++++
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, memory
// width codes, RISC-V load/store funct3 encodings and exception cause codes.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } lsu_state_e;

    localparam logic [1:0] WIDTH_NONE = 2'd0;
    localparam logic [1:0] WIDTH_B    = 2'd1;
    localparam logic [1:0] WIDTH_H    = 2'd2;
    localparam logic [1:0] WIDTH_W    = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] EXC_NONE        = 4'd0;
    localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    // Access width implied by funct3; unknown codes map to WIDTH_NONE.
    function automatic logic [1:0] f3_width(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: f3_width = WIDTH_B;
            F3_H, F3_HU: f3_width = WIDTH_H;
            F3_W:        f3_width = WIDTH_W;
            default:     f3_width = WIDTH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/lsu_decode.sv
// Combinational request decode for the load/store unit: width, zero-extend,
// and exception detection (illegal > misaligned > access fault).
// Misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_decode
    import lsu_pkg::*;
#(
    parameter logic [3:0] BROM_BASE = 4'h1,
    parameter logic [3:0] IMEM_BASE = 4'h2,
    parameter logic [3:0] DMEM_BASE = 4'h4,
    parameter logic [3:0] PERI_BASE = 4'h8
) (
    input  logic [2:0] funct3,
    input  logic       is_load,
    input  logic       is_store,
    input  logic [3:0] addr_hi,
    input  logic [1:0] addr_lo,
    output logic [1:0] width,
    output logic       zeroextend,
    output logic       exc,
    output logic [3:0] cause
);

    logic ld_ok;
    logic st_ok;
    logic access;
    logic illegal;
    logic misalign;
    logic in_map;
    logic fault;

`ifndef LSU_MISALIGN_TRAP_EN
    // Low address bits only matter when misalignment traps are built in.
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr_lo;
`endif

    // Classify the request and pick the highest-priority exception.
    always_comb begin
        width      = f3_width(funct3);
        zeroextend = funct3[2];
        access     = is_load || is_store;
        ld_ok      = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                     (funct3 == F3_BU) || (funct3 == F3_HU);
        st_ok      = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        illegal    = (is_load && is_store) || (is_load && !ld_ok) || (is_store && !st_ok);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign   = access && (((width == WIDTH_H) && addr_lo[0]) ||
                                ((width == WIDTH_W) && (addr_lo != 2'b00)));
`else
        misalign   = 1'b0;
`endif
        in_map     = (addr_hi == BROM_BASE) || (addr_hi == IMEM_BASE) ||
                     (addr_hi == DMEM_BASE) || (addr_hi == PERI_BASE);
        fault      = access && (!in_map || (is_store && (addr_hi == BROM_BASE)));

        exc   = 1'b1;
        cause = EXC_NONE;
        if (illegal) begin
            cause = EXC_ILLEGAL;
        end else if (misalign) begin
            cause = is_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
        end else if (fault) begin
            cause = is_load ? EXC_LD_FAULT : EXC_ST_FAULT;
        end else begin
            exc = 1'b0;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store memory stage: accepts one request at a time, issues a single
// registered strobe to the memory controller (held across stalls), captures
// load data the cycle after the strobe and returns a writeback, a done pulse
// or an exception pulse. Build option: LSU_MISALIGN_TRAP_EN (see lsu_decode).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [3:0] BROM_BASE = 4'h1,
    parameter logic [3:0] IMEM_BASE = 4'h2,
    parameter logic [3:0] DMEM_BASE = 4'h4,
    parameter logic [3:0] PERI_BASE = 4'h8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [4:0]  i_rd,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [1:0]  o_mem_width,
    output logic        o_mem_we,
    output logic        o_mem_re,
    output logic        o_mem_zeroextend,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_stall,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_done,
    output logic        o_exc,
    output logic [3:0]  o_exc_cause,
    output logic [31:0] o_exc_tval
);

    lsu_state_e state_q;
    lsu_state_e state_d;

    logic [1:0] dec_width;
    logic       dec_zx;
    logic       dec_exc;
    logic [3:0] dec_cause;

    logic       accept;
    logic       noop;
    logic       is_load_p0;
    logic [4:0] rd_p0;

    logic       re_d;
    logic       we_d;
    logic       done_d;
    logic       exc_d;
    logic       vld_p1_d;

    assign o_ready = (state_q == IDLE) && !i_rst;
    assign accept  = i_valid && o_ready;
    assign noop    = !i_is_load && !i_is_store;

    lsu_decode #(
        .BROM_BASE (BROM_BASE),
        .IMEM_BASE (IMEM_BASE),
        .DMEM_BASE (DMEM_BASE),
        .PERI_BASE (PERI_BASE)
    ) u_decode (
        .funct3     (i_funct3),
        .is_load    (i_is_load),
        .is_store   (i_is_store),
        .addr_hi    (i_addr[31:28]),
        .addr_lo    (i_addr[1:0]),
        .width      (dec_width),
        .zeroextend (dec_zx),
        .exc        (dec_exc),
        .cause      (dec_cause)
    );

    // State register; reset aborts any transaction in flight immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only real accesses leave IDLE; stall pins the unit in ISSUE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !dec_exc && !noop) state_d = ISSUE;
            ISSUE:   if (!i_mem_stall) state_d = is_load_p0 ? RESP : IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of strobes and one-cycle pulses.
    always_comb begin
        re_d     = 1'b0;
        we_d     = 1'b0;
        done_d   = 1'b0;
        exc_d    = 1'b0;
        vld_p1_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_exc) begin
                        exc_d = 1'b1;
                    end else if (noop) begin
                        done_d = 1'b1;
                    end else begin
                        re_d = i_is_load;
                        we_d = i_is_store;
                    end
                end
            end
            ISSUE: begin
                if (i_mem_stall) begin
                    re_d = o_mem_re;
                    we_d = o_mem_we;
                end else begin
                    done_d = !is_load_p0;
                end
            end
            RESP:    vld_p1_d = 1'b1;
            default: ;
        endcase
    end

    // Output and request registers: latched on accept, load data on RESP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mem_re         <= 1'b0;
            o_mem_we         <= 1'b0;
            o_done           <= 1'b0;
            o_exc            <= 1'b0;
            o_wb_valid       <= 1'b0;
            o_mem_addr       <= '0;
            o_mem_wdata      <= '0;
            o_mem_width      <= '0;
            o_mem_zeroextend <= 1'b0;
            o_exc_cause      <= '0;
            o_exc_tval       <= '0;
            o_wb_rd          <= '0;
            o_wb_data        <= '0;
            is_load_p0       <= 1'b0;
            rd_p0            <= '0;
        end else begin
            o_mem_re   <= re_d;
            o_mem_we   <= we_d;
            o_done     <= done_d;
            o_exc      <= exc_d;
            o_wb_valid <= vld_p1_d;
            if (accept) begin
                o_mem_addr       <= i_addr;
                o_mem_wdata      <= i_wdata;
                o_mem_width      <= dec_width;
                o_mem_zeroextend <= dec_zx;
                is_load_p0       <= i_is_load;
                rd_p0            <= i_rd;
                if (dec_exc) begin
                    o_exc_cause <= dec_cause;
                    o_exc_tval  <= i_addr;
                end
            end
            if (state_q == RESP) begin
                o_wb_data <= i_mem_rdata;
                o_wb_rd   <= rd_p0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed transactions, a per-cycle
// expected timeline built from the request rules, and a negedge compare.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [2:0]  i_funct3 = '0;
    logic        i_is_load = 1'b0;
    logic        i_is_store = 1'b0;
    logic [4:0]  i_rd = '0;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [1:0]  o_mem_width;
    logic        o_mem_we;
    logic        o_mem_re;
    logic        o_mem_zeroextend;
    logic [31:0] i_mem_rdata = 32'hBAD0_BAD0;
    logic        i_mem_stall = 1'b0;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_done;
    logic        o_exc;
    logic [3:0]  o_exc_cause;
    logic [31:0] o_exc_tval;

    load_store_unit dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_funct3(i_funct3),
        .i_is_load(i_is_load), .i_is_store(i_is_store), .i_rd(i_rd),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_width(o_mem_width),
        .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .o_mem_zeroextend(o_mem_zeroextend),
        .i_mem_rdata(i_mem_rdata), .i_mem_stall(i_mem_stall),
        .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
        .o_done(o_done), .o_exc(o_exc), .o_exc_cause(o_exc_cause), .o_exc_tval(o_exc_tval)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          busy;
        bit          re;
        bit          we;
        bit          done;
        bit          wb;
        bit          exc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        bit          zx;
        logic [4:0]  rd;
        logic [31:0] wbdata;
        logic [3:0]  cause;
        logic [31:0] tval;
    } exp_t;

    localparam int TL_N = 4096;
    exp_t tl [TL_N];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int wb_count = 0;
    logic [31:0] last_wb_data = '0;
    logic [4:0]  last_wb_rd = '0;
    logic [3:0]  last_cause = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    // Reference rules for the result of one request.
    function automatic logic [3:0] spec_cause(input bit ld, input bit st,
                                              input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] nib;
        nib = a[31:28];
        if (ld && st) return 4'd2;
        if (!ld && !st) return 4'd0;
        if (ld && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 4'd2;
        if (st && f3 > 3'd2) return 4'd2;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0))
            return ld ? 4'd4 : 4'd6;
`endif
        if (!(nib == 4'h1 || nib == 4'h2 || nib == 4'h4 || nib == 4'h8) || (st && nib == 4'h1))
            return ld ? 4'd5 : 4'd7;
        return 4'd0;
    endfunction

    function automatic logic [1:0] spec_width(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 2'd1;
            3'd1, 3'd5: return 2'd2;
            3'd2:       return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

    task automatic clear_tl();
        for (int i = 0; i < TL_N; i++) tl[i] = '{default: '0};
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic expect_access(input int n, input bit ld, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [4:0] rd, input logic [31:0] rdat, input int s);
        for (int k = 1; k <= 1 + s; k++) begin
            tl[n+k].busy  = 1'b1;
            tl[n+k].re    = ld;
            tl[n+k].we    = !ld;
            tl[n+k].addr  = a;
            tl[n+k].wdata = wd;
            tl[n+k].width = spec_width(f3);
            tl[n+k].zx    = f3[2];
        end
        if (ld) begin
            tl[n+2+s].busy   = 1'b1;
            tl[n+3+s].wb     = 1'b1;
            tl[n+3+s].rd     = rd;
            tl[n+3+s].wbdata = rdat;
        end else begin
            tl[n+2+s].done = 1'b1;
        end
    endtask

    // Drive one request (called at posedge+1 with the unit idle) and record
    // its expected outputs; returns in the cycle of its final pulse.
    task automatic do_txn(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdat, input int s_in);
        int n;
        int s;
        logic [3:0] c;
        bit acc;
        n   = cyc;
        c   = spec_cause(ld, st, f3, a);
        acc = (ld ^ st) && (c == 4'd0);
        s   = acc ? s_in : 0;
        if (c != 4'd0) begin
            tl[n+1].exc   = 1'b1;
            tl[n+1].cause = c;
            tl[n+1].tval  = a;
        end else if (!ld && !st) begin
            tl[n+1].done = 1'b1;
        end else begin
            expect_access(n, ld, f3, a, wd, rd, rdat, s);
        end
        i_valid    = 1'b1;
        i_addr     = a;
        i_wdata    = wd;
        i_funct3   = f3;
        i_is_load  = ld;
        i_is_store = st;
        i_rd       = rd;
        tick();
        i_valid    = 1'b0;
        i_is_load  = 1'b0;
        i_is_store = 1'b0;
        if (acc) begin
            if (s > 0) begin
                i_mem_stall = 1'b1;
                repeat (s) tick();
                i_mem_stall = 1'b0;
            end
            tick();
            if (ld) begin
                i_mem_rdata = rdat;
                tick();
                i_mem_rdata = 32'hBAD0_BAD0;
            end
        end
    endtask

    // Per-cycle comparison of every output against the expected timeline.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_wb_valid) begin
                wb_count++;
                last_wb_data = o_wb_data;
                last_wb_rd   = o_wb_rd;
            end
            if (o_exc) last_cause = o_exc_cause;
        end
        if (chk_en && !i_rst && cyc < TL_N) begin
            chk1("o_ready", o_ready, !tl[cyc].busy);
            chk1("o_mem_re", o_mem_re, tl[cyc].re);
            chk1("o_mem_we", o_mem_we, tl[cyc].we);
            chk1("o_done", o_done, tl[cyc].done);
            chk1("o_wb_valid", o_wb_valid, tl[cyc].wb);
            chk1("o_exc", o_exc, tl[cyc].exc);
            if (tl[cyc].re || tl[cyc].we) begin
                chk32("o_mem_addr", o_mem_addr, tl[cyc].addr);
                chk32("o_mem_width", 32'(o_mem_width), 32'(tl[cyc].width));
                chk1("o_mem_zeroextend", o_mem_zeroextend, tl[cyc].zx);
                if (tl[cyc].we) chk32("o_mem_wdata", o_mem_wdata, tl[cyc].wdata);
            end
            if (tl[cyc].wb) begin
                chk32("o_wb_rd", 32'(o_wb_rd), 32'(tl[cyc].rd));
                chk32("o_wb_data", o_wb_data, tl[cyc].wbdata);
            end
            if (tl[cyc].exc) begin
                chk32("o_exc_cause", 32'(o_exc_cause), 32'(tl[cyc].cause));
                chk32("o_exc_tval", o_exc_tval, tl[cyc].tval);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wb_before;
        clear_tl();
        // Reset state
        #2;
        chk1("rst o_ready", o_ready, 1'b0);
        chk1("rst o_mem_re", o_mem_re, 1'b0);
        chk1("rst o_mem_we", o_mem_we, 1'b0);
        chk1("rst o_wb_valid", o_wb_valid, 1'b0);
        chk1("rst o_done", o_done, 1'b0);
        chk1("rst o_exc", o_exc, 1'b0);
        chk32("rst o_mem_addr", o_mem_addr, 32'h0);
        chk32("rst o_wb_data", o_wb_data, 32'h0);
        repeat (2) tick();
        i_rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // LW, data returned
        do_txn(1, 0, 3'b010, 32'h4000_0010, 32'h0, 5'd5, 32'hDEADBEEF, 0);
        tick();
        chk32("lw data literal", last_wb_data, 32'hDEADBEEF);
        chk32("lw rd literal", 32'(last_wb_rd), 32'd5);

        // SB to peripheral with a 3-cycle stall
        do_txn(0, 1, 3'b000, 32'h8000_0003, 32'h0000_005A, 5'd0, 32'h0, 3);
        tick();

        // SW to boot ROM faults
        do_txn(0, 1, 3'b010, 32'h1000_0000, 32'h1234_5678, 5'd0, 32'h0, 0);
        tick();
        chk32("sw brom cause literal", 32'(last_cause), 32'd7);

        // LH at odd address
        wb_before = wb_count;
        do_txn(1, 0, 3'b001, 32'h4000_0001, 32'h0, 5'd7, 32'hFFFF_8001, 0);
        tick();
`ifdef LSU_MISALIGN_TRAP_EN
        chk32("lh misalign cause literal", 32'(last_cause), 32'd4);
`else
        chk32("lh odd wb literal", last_wb_data, 32'hFFFF_8001);
        chk32("lh odd wb count", 32'(wb_count), 32'(wb_before + 1));
`endif

        // Illegal funct3 load, unmapped load
        do_txn(1, 0, 3'b011, 32'h4000_0000, 32'h0, 5'd1, 32'h0, 0);
        tick();
        chk32("f3=011 cause literal", 32'(last_cause), 32'd2);
        do_txn(1, 0, 3'b000, 32'h3000_0000, 32'h0, 5'd1, 32'h0, 0);
        tick();
        chk32("unmapped load cause literal", 32'(last_cause), 32'd5);

        // No-op, both types high, then back-to-back accesses
        do_txn(0, 0, 3'b010, 32'h4000_0000, 32'h0, 5'd0, 32'h0, 0);
        do_txn(1, 1, 3'b010, 32'h4000_0000, 32'h0, 5'd2, 32'h0, 0);
        do_txn(1, 0, 3'b100, 32'h2000_0002, 32'h0, 5'd9, 32'h0000_00AB, 1);
        do_txn(0, 1, 3'b001, 32'h4000_0006, 32'h0000_BEEF, 5'd0, 32'h0, 0);
        do_txn(0, 1, 3'b100, 32'h4000_0000, 32'h0, 5'd0, 32'h0, 0);
        do_txn(0, 1, 3'b010, 32'h4000_0002, 32'hCAFE_F00D, 5'd0, 32'h0, 0);
        do_txn(1, 0, 3'b101, 32'h8000_0010, 32'h0, 5'd31, 32'h0000_7FFF, 2);
        tick();
        chk32("lhu data literal", last_wb_data, 32'h0000_7FFF);
        chk32("model lw width literal", 32'(spec_width(3'b010)), 32'd3);
        chk32("model lhu width literal", 32'(spec_width(3'b101)), 32'd2);

        // Reset asserted while a load is stalled in ISSUE
        wb_before = wb_count;
        n = cyc;
        expect_access(n, 1, 3'b010, 32'h4000_0020, 32'h0, 5'd3, 32'h0, 6);
        i_valid = 1'b1; i_addr = 32'h4000_0020; i_funct3 = 3'b010;
        i_is_load = 1'b1; i_is_store = 1'b0; i_rd = 5'd3;
        tick();
        i_valid = 1'b0; i_is_load = 1'b0;
        i_mem_stall = 1'b1;
        tick();
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        clear_tl();
        #1;
        chk1("abort o_mem_re", o_mem_re, 1'b0);
        chk1("abort o_mem_we", o_mem_we, 1'b0);
        chk1("abort o_ready", o_ready, 1'b0);
        i_mem_stall = 1'b0;
        repeat (2) tick();
        i_rst = 1'b0;
        #1;
        chk1("post-reset o_ready", o_ready, 1'b1);
        repeat (5) tick();
        chk32("no wb after abort", 32'(wb_count), 32'(wb_before));

        // Unit still works after the abort
        do_txn(1, 0, 3'b010, 32'h4000_0040, 32'h0, 5'd4, 32'h0BAD_F00D, 0);
        repeat (2) tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
